sram_port_arbiter: RTL



---
 rtl/sram_arb_pkg.sv | 27 ++
 rtl/sram_port_arbiter_if.sv | 23 ++
 rtl/sram_arb_pick.sv | 50 +++++
 rtl/sram_port_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam int WAIT_CYCLES_DEF  = 3;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } req_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side port bundle: one request/response channel into the arbiter.
interface sram_port_arbiter_if;
    import sram_arb_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_arb_pick.sv
// Winner selection between I and D; D has priority unless the optional
// starvation guard (SRAM_ARB_STARVE_GUARD_EN) forces I through.
module sram_arb_pick
    import sram_arb_pkg::*;
`ifdef SRAM_ARB_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)
`endif
(
`ifdef SRAM_ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic arb_en,
    input  logic i_valid,
    input  logic d_valid,
    output logic i_ready,
    output logic d_ready
);

    logic i_win;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       force_i;

    assign force_i = (starve_cnt == LIMIT) & i_valid & d_valid;
    assign i_win   = i_valid & (~d_valid | force_i);

    // Counts D grants that I had to sit out; saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (i_ready) begin
            starve_cnt <= 4'd0;
        end else if (d_ready && i_valid && starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign i_win = i_valid & ~d_valid;
`endif

    assign i_ready = arb_en & i_win;
    assign d_ready = arb_en & d_valid & ~i_win;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM wrapper port between the I-fetch and D ports, one access at a time.
// Optional starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
//
// state  | meaning
// IDLE   | arbitrate; ready goes to the winner only
// ACCESS | SRAM controls held from latched request for WAIT_CYCLES cycles
// RESP   | one-cycle resp_valid pulse to the owner
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
`ifdef SRAM_ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_port_arbiter_if.slave i_port,
    sram_port_arbiter_if.slave d_port,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic [MASK_W-1:0] sram_wmask,
    output logic              sram_en,
    output logic              sram_re,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt;
    logic              owner;
    req_t              lat;
    logic [DATA_W-1:0] rdata;
    logic              i_ready, d_ready;
    logic              i_accept, d_accept, accept;
    logic              last_cycle;
    req_t              i_req, d_req;

    assign i_req = '{addr: i_port.req_addr, we: i_port.req_we,
                     wdata: i_port.req_wdata, wmask: i_port.req_wmask};
    assign d_req = '{addr: d_port.req_addr, we: d_port.req_we,
                     wdata: d_port.req_wdata, wmask: d_port.req_wmask};

    sram_arb_pick
`ifdef SRAM_ARB_STARVE_GUARD_EN
        #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
        u_pick (
`ifdef SRAM_ARB_STARVE_GUARD_EN
        .clk     (clk),
        .rst_n   (rst_n),
`endif
        .arb_en  (state == IDLE),
        .i_valid (i_port.req_valid),
        .d_valid (d_port.req_valid),
        .i_ready (i_ready),
        .d_ready (d_ready)
    );

    assign i_port.req_ready = i_ready;
    assign d_port.req_ready = d_ready;
    assign i_accept   = i_port.req_valid & i_ready;
    assign d_accept   = d_port.req_valid & d_ready;
    assign accept     = i_accept | d_accept;
    assign last_cycle = (state == ACCESS) && (wait_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  if (last_cycle) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sram_en           = 1'b0;
        sram_re           = 1'b0;
        sram_we           = 1'b0;
        i_port.resp_valid = 1'b0;
        d_port.resp_valid = 1'b0;
        case (state)
            ACCESS: begin
                sram_en = 1'b1;
                sram_re = ~lat.we;
                sram_we = lat.we;
            end
            RESP: begin
                i_port.resp_valid = (owner == OWNER_I);
                d_port.resp_valid = (owner == OWNER_D);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= OWNER_D;
            lat      <= '0;
            wait_cnt <= 4'd0;
            rdata    <= '0;
        end else if (accept) begin
            owner    <= d_accept ? OWNER_D : OWNER_I;
            lat      <= d_accept ? d_req : i_req;
            wait_cnt <= 4'd0;
        end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt + 4'd1;
            if (last_cycle && !lat.we) rdata <= sram_dout;
        end
    end

    // Address/data/mask come straight from the latch so they stay put for the whole access.
    assign sram_addr  = lat.addr;
    assign sram_din   = lat.wdata;
    assign sram_wmask = lat.wmask;

    assign i_port.resp_rdata = rdata;
    assign d_port.resp_rdata = rdata;

endmodule
